mdu_iter: RTL and testbench

- Iterative RV64M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Takes ops the ALU cannot do in one cycle: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W variants.
- Processes one result bit per cycle and holds the pipeline through a valid/ready handshake.
- Carries a destination tag through so writeback can retire the result.

---
 rtl/mdu_pkg.sv | 73 +++++++
 rtl/mdu_signfix.sv | 35 +++
 rtl/mdu_iter.sv | 232 +++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared types and helpers for the iterative RV64M multiply/divide
//            unit: operation and state encodings, an operation decode record
//            and the W-op classifier.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_MUL    = 4'd0,
    MDU_MULH   = 4'd1,
    MDU_MULHSU = 4'd2,
    MDU_MULHU  = 4'd3,
    MDU_DIV    = 4'd4,
    MDU_DIVU   = 4'd5,
    MDU_REM    = 4'd6,
    MDU_REMU   = 4'd7,
    MDU_MULW   = 4'd8,
    MDU_DIVW   = 4'd9,
    MDU_DIVUW  = 4'd10,
    MDU_REMW   = 4'd11,
    MDU_REMUW  = 4'd12
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  // Per-op control record produced at accept time.
  typedef struct packed {
    logic is_mul;  // multiply family (else divide family)
    logic is_rem;  // divide family returns remainder
    logic hi;      // multiply returns the upper XLEN bits
    logic sgn_a;   // rs1 treated as signed (also selects W sign-extension)
    logic sgn_b;   // rs2 treated as signed
    logic w;       // 32-bit W variant
  } mdu_dec_t;

  function automatic logic is_w_op(input logic [3:0] op);
    return (op == MDU_MULW)  || (op == MDU_DIVW) || (op == MDU_DIVUW) ||
           (op == MDU_REMW)  || (op == MDU_REMUW);
  endfunction

  // Unknown encodings fall through to plain MUL.
  function automatic mdu_dec_t decode_op(input logic [3:0] op);
    mdu_dec_t d;
    d        = '0;
    d.is_mul = 1'b1;
    d.w      = is_w_op(op);
    case (op)
      MDU_MULH:   begin d.hi = 1'b1; d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
      MDU_MULHSU: begin d.hi = 1'b1; d.sgn_a = 1'b1; end
      MDU_MULHU:  begin d.hi = 1'b1; end
      MDU_DIV:    begin d.is_mul = 1'b0; d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
      MDU_DIVU:   begin d.is_mul = 1'b0; end
      MDU_REM:    begin d.is_mul = 1'b0; d.is_rem = 1'b1; d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
      MDU_REMU:   begin d.is_mul = 1'b0; d.is_rem = 1'b1; end
      MDU_MULW:   begin d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
      MDU_DIVW:   begin d.is_mul = 1'b0; d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
      MDU_DIVUW:  begin d.is_mul = 1'b0; end
      MDU_REMW:   begin d.is_mul = 1'b0; d.is_rem = 1'b1; d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
      MDU_REMUW:  begin d.is_mul = 1'b0; d.is_rem = 1'b1; end
      default:    begin d.sgn_a = 1'b1; d.sgn_b = 1'b1; end
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_signfix.sv
`default_nettype none
// ============================================================================
// Module   : mdu_signfix
// Purpose  : Final result shaping: optional two's-complement negation of the
//            raw magnitude, half select, and W-op sign extension of bit 31.
// Ports    : raw_i  [2*XLEN] unsigned magnitude (product, quotient or rem)
//            neg_i           negate the magnitude
//            hi_i            return the upper XLEN bits
//            w_i             sign-extend bit 31 to XLEN
//            res_o  [XLEN]   final result
// Revision : 1.0 - initial release
// ============================================================================
module mdu_signfix #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] raw_i,
  input  logic              neg_i,
  input  logic              hi_i,
  input  logic              w_i,
  output logic [XLEN-1:0]   res_o
);

  logic [2*XLEN-1:0] w_fixed;
  logic [XLEN-1:0]   w_half;

  always_comb begin
    // Negation over the full double width so the high half of a signed
    // product picks up the borrow from the low half.
    w_fixed = neg_i ? -raw_i : raw_i;
    w_half  = hi_i ? w_fixed[2*XLEN-1:XLEN] : w_fixed[XLEN-1:0];
    res_o   = w_i ? XLEN'($signed(w_half[31:0])) : w_half;
  end

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Purpose  : Iterative RV64M multiply/divide unit, one result bit per cycle.
//            Multiply is right-shifting shift-add, divide is restoring
//            shift-subtract; both work on operand magnitudes and the sign is
//            fixed up when the result is presented.
// Ports    : clk, reset (sync, active high), flush (kill in-flight op)
//            in_valid/in_ready, in_op[4], in_a/in_b[XLEN], in_tag[TAG_W]
//            out_valid/out_ready, out_result[XLEN], out_tag[TAG_W]
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int c_cnt_w = $clog2(XLEN + 1);
  localparam int c_pw    = 2 * XLEN;
  localparam logic [XLEN-1:0] c_min_x = ~({XLEN{1'b1}} >> 1);
  // Most-negative 32-bit value already sign-extended to XLEN.
  localparam logic [XLEN-1:0] c_min_w = ~(XLEN'(32'h7FFF_FFFF));

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  mdu_state_t         state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [c_pw-1:0]    acc_q;    // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]    m_q;      // multiplicand / divisor magnitude
  logic [c_cnt_w-1:0] cnt_q;    // steps remaining
  logic [TAG_W-1:0]   tag_q;
  logic               mul_q;
  logic               rem_q;
  logic               hi_q;
  logic               w_q;
  logic               neg_q;
  logic               hold_q;   // special-case result already in acc_q

  // --------------------------------------------------------------------------
  // Accept-side decode and operand conditioning
  // --------------------------------------------------------------------------
  mdu_dec_t        w_dec;
  logic            w_w;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;
  logic            w_a_neg, w_b_neg, w_div_zero, w_ovf, w_neg;
  logic [XLEN-1:0] w_min;

  always_comb begin
    w_dec = decode_op(in_op);
    w_w   = (XLEN == 64) && w_dec.w;
    if (w_w) begin
      w_a_ext = w_dec.sgn_a ? XLEN'($signed(in_a[31:0])) : XLEN'(in_a[31:0]);
      w_b_ext = w_dec.sgn_b ? XLEN'($signed(in_b[31:0])) : XLEN'(in_b[31:0]);
    end else begin
      w_a_ext = in_a;
      w_b_ext = in_b;
    end
    w_a_neg    = w_dec.sgn_a & w_a_ext[XLEN-1];
    w_b_neg    = w_dec.sgn_b & w_b_ext[XLEN-1];
    w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
    w_min      = w_w ? c_min_w : c_min_x;
    w_div_zero = !w_dec.is_mul && (w_b_ext == '0);
    w_ovf      = !w_dec.is_mul && w_dec.sgn_a && (w_a_ext == w_min) &&
                 (w_b_ext == {XLEN{1'b1}});
    // Remainder follows the dividend; product and quotient follow a^b.
    w_neg      = (!w_dec.is_mul && w_dec.is_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
  end

  // --------------------------------------------------------------------------
  // One iteration step
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_hi, w_lo;
  logic [XLEN:0]   w_sum, w_shl, w_diff;
  logic [c_pw-1:0] w_acc_step;

  assign w_hi = acc_q[c_pw-1:XLEN];
  assign w_lo = acc_q[XLEN-1:0];

  always_comb begin
    // Multiply: add multiplicand when the current multiplier bit is set, then
    // shift the whole accumulator right with the carry coming in at the top.
    w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
    // Divide: shift the next dividend bit into the partial remainder and keep
    // the difference only if it did not borrow.
    w_shl  = {w_hi, w_lo[XLEN-1]};
    w_diff = w_shl - {1'b0, m_q};
    if (mul_q) begin
      w_acc_step = {w_sum, w_lo[XLEN-1:1]};
    end else if (!w_diff[XLEN]) begin
      w_acc_step = {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
    end else begin
      w_acc_step = {w_shl[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      mul_q       <= 1'b0;
      rem_q       <= 1'b0;
      hi_q        <= 1'b0;
      w_q         <= 1'b0;
      neg_q       <= 1'b0;
      hold_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q    <= ST_BUSY;
            in_ready_q <= 1'b0;
            tag_q      <= in_tag;
            mul_q      <= w_dec.is_mul;
            rem_q      <= w_dec.is_rem;
            hi_q       <= w_dec.hi && !w_w;
            w_q        <= w_w;
            m_q        <= w_dec.is_mul ? w_a_mag : w_b_mag;
            if (w_div_zero) begin
              // Quotient all ones, remainder the (extended) dividend.
              acc_q  <= {w_a_ext, {XLEN{1'b1}}};
              neg_q  <= 1'b0;
              hold_q <= 1'b1;
              cnt_q  <= c_cnt_w'(1);
            end else if (w_ovf) begin
              acc_q  <= {{XLEN{1'b0}}, w_min};
              neg_q  <= 1'b0;
              hold_q <= 1'b1;
              cnt_q  <= c_cnt_w'(1);
            end else begin
              neg_q  <= w_neg;
              hold_q <= 1'b0;
              cnt_q  <= w_w ? c_cnt_w'(32) : c_cnt_w'(XLEN);
              if (w_dec.is_mul) begin
                acc_q <= {{XLEN{1'b0}}, w_b_mag};
              end else begin
                // W dividends are left-aligned so 32 steps consume them fully.
                acc_q <= {{XLEN{1'b0}}, (w_w ? (w_a_mag << (XLEN - 32)) : w_a_mag)};
              end
            end
          end
        end
        ST_BUSY: begin
          if (!hold_q) begin
            acc_q <= w_acc_step;
          end
          cnt_q <= cnt_q - c_cnt_w'(1);
          if (cnt_q == c_cnt_w'(1)) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result presentation
  // --------------------------------------------------------------------------
  logic [c_pw-1:0] w_raw;
  logic [XLEN-1:0] w_fixed;

  always_comb begin
    if (mul_q) begin
      // After 32 right-shift steps the W product sits XLEN-32 bits up.
      w_raw = w_q ? (acc_q >> (XLEN - 32)) : acc_q;
    end else if (rem_q) begin
      w_raw = {{XLEN{1'b0}}, w_hi};
    end else begin
      w_raw = {{XLEN{1'b0}}, w_lo};
    end
  end

  mdu_signfix #(
    .XLEN (XLEN)
  ) u_signfix (
    .raw_i (w_raw),
    .neg_i (neg_q),
    .hi_i  (hi_q),
    .w_i   (w_q),
    .res_o (w_fixed)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_valid_q ? w_fixed : '0;
  assign out_tag    = out_valid_q ? tag_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Purpose  : Self-checking bench for mdu_iter: directed corner cases plus
//            random ops compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op;
  logic [63:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(64), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model straight from the ISA arithmetic rules.
  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic signed [127:0] sa, sb, sp;
    logic [127:0]        up;
    logic signed [63:0]  s64a, s64b;
    logic signed [31:0]  s32a, s32b;
    logic [31:0]         u32a, u32b, r32;
    logic [63:0]         min64, p64;
    min64 = 64'h8000_0000_0000_0000;
    s64a = a; s64b = b;
    u32a = a[31:0]; u32b = b[31:0];
    s32a = a[31:0]; s32b = b[31:0];
    case (op)
      MDU_MULH: begin
        sa = $signed({{64{a[63]}}, a}); sb = $signed({{64{b[63]}}, b});
        sp = sa * sb; return sp[127:64];
      end
      MDU_MULHSU: begin
        sa = $signed({{64{a[63]}}, a}); sb = $signed({64'd0, b});
        sp = sa * sb; return sp[127:64];
      end
      MDU_MULHU: begin
        up = {64'd0, a} * {64'd0, b}; return up[127:64];
      end
      MDU_DIV: begin
        if (b == 64'd0) return '1;
        if (a == min64 && b == '1) return min64;
        p64 = s64a / s64b; return p64;
      end
      MDU_REM: begin
        if (b == 64'd0) return a;
        if (a == min64 && b == '1) return 64'd0;
        p64 = s64a % s64b; return p64;
      end
      MDU_DIVU: return (b == 64'd0) ? '1 : a / b;
      MDU_REMU: return (b == 64'd0) ? a : a % b;
      MDU_MULW: begin r32 = u32a * u32b; return sx32(r32); end
      MDU_DIVW: begin
        if (u32b == 32'd0) return '1;
        if (u32a == 32'h8000_0000 && u32b == 32'hFFFF_FFFF) return sx32(32'h8000_0000);
        r32 = s32a / s32b; return sx32(r32);
      end
      MDU_REMW: begin
        if (u32b == 32'd0) return sx32(u32a);
        if (u32a == 32'h8000_0000 && u32b == 32'hFFFF_FFFF) return 64'd0;
        r32 = s32a % s32b; return sx32(r32);
      end
      MDU_DIVUW: begin
        if (u32b == 32'd0) return '1;
        r32 = u32a / u32b; return sx32(r32);
      end
      MDU_REMUW: begin
        if (u32b == 32'd0) return sx32(u32a);
        r32 = u32a % u32b; return sx32(r32);
      end
      default: begin p64 = a * b; return p64; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [63:0] a,
                                     input logic [63:0] b);
    logic is_w, is_div, is_sdiv;
    is_w    = op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    is_div  = op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
                         MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    is_sdiv = op inside {MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
    if (is_div) begin
      if (is_w) begin
        if (b[31:0] == 32'd0) return 1;
        if (is_sdiv && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      end else begin
        if (b == 64'd0) return 1;
        if (is_sdiv && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
      end
    end
    return is_w ? 32 : 64;
  endfunction

  // Issue one op, check latency, busy behaviour, result, tag, stall stability
  // for 'hold' cycles, then retire it.
  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input int hold);
    logic [63:0] exp_res;
    int          exp_lat, cyc, n;
    logic        busy_ok, stall_ok;
    exp_res = ref_model(op, a, b);
    exp_lat = ref_latency(op, a, b);
    n = 0;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    chk({name, " ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    in_tag = 5'($urandom);
    cyc = 0; busy_ok = 1'b1;
    while (!out_valid && cyc < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({name, " busy"}, 64'(busy_ok), 64'd1);
    chk({name, " result"}, out_result, exp_res);
    chk({name, " tag"}, 64'(out_tag), 64'(tag));
    if (hold > 0) begin
      stall_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!out_valid || in_ready || out_result !== exp_res || out_tag !== tag)
          stall_ok = 1'b0;
      end
      chk({name, " stall"}, 64'(stall_ok), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " retire"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  // Start an op and abort it with flush or reset ten steps in.
  task automatic abort_op(input string name, input logic use_reset);
    logic seen;
    in_valid = 1'b1; in_op = MDU_MUL; in_a = 64'd3; in_b = 64'd4; in_tag = 5'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0;
    chk({name, " idle"}, {62'd0, out_valid, in_ready}, 64'd1);
    chk({name, " outs"}, out_result | 64'(out_tag), 64'd0);
    seen = 1'b0;
    repeat (80) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk({name, " no result"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    int          mode;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    chk("reset ready", 64'(in_ready), 64'd1);
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset outs", out_result | 64'(out_tag), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul", MDU_MUL, 64'd7, -64'sd3, 5'd1, 0);
    run_op("mulhu", MDU_MULHU, '1, '1, 5'd2, 0);
    run_op("mulhsu", MDU_MULHSU, '1, 64'd2, 5'd3, 0);
    run_op("div", MDU_DIV, -64'sd7, 64'd2, 5'd4, 0);
    run_op("rem", MDU_REM, -64'sd7, 64'd2, 5'd5, 0);
    run_op("remu0", MDU_REMU, 64'd5, 64'd0, 5'd6, 0);
    run_op("divu0", MDU_DIVU, 64'd5, 64'd0, 5'd7, 0);
    run_op("divovf", MDU_DIV, 64'h8000_0000_0000_0000, '1, 5'd8, 0);
    run_op("removf", MDU_REM, 64'h8000_0000_0000_0000, '1, 5'd9, 0);
    run_op("mulw", MDU_MULW, 64'h7FFF_FFFF, 64'd2, 5'd10, 0);
    run_op("divuw", MDU_DIVUW, 64'hFFFF_FFFF, 64'd1, 5'd11, 0);
    run_op("divw", MDU_DIVW, 64'h1_0000_0006, 64'd3, 5'd12, 0);
    run_op("remuw0", MDU_REMUW, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 5'd13, 0);
    run_op("badop", 4'hF, 64'd3, 64'd5, 5'd14, 0);
    run_op("stall", MDU_MULH, 64'hDEAD_BEEF_0000_1234, 64'h8765_4321_FFFF_0001, 5'd21, 5);

    // flush beats an accept in the same cycle
    in_valid = 1'b1; in_op = MDU_MUL; in_a = 64'd1; in_b = 64'd1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush vs accept", {62'd0, out_valid, in_ready}, 64'd1);

    abort_op("flush", 1'b0);
    run_op("post flush", MDU_DIVU, 64'd100, 64'd7, 5'd15, 0);
    abort_op("reset", 1'b1);
    run_op("post reset", MDU_REM, 64'd100, -64'sd7, 5'd16, 1);

    for (int i = 0; i < 30; i++) begin
      op   = 4'($urandom_range(0, 12));
      mode = $urandom_range(0, 5);
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      case (mode)
        0: b = ($urandom_range(0, 1) == 0) ? 64'd0 : {b[63:32], 32'd0};
        1: begin
          a = ($urandom_range(0, 1) == 0) ? 64'h8000_0000_0000_0000 : {a[63:32], 32'h8000_0000};
          b = ($urandom_range(0, 1) == 0) ? '1 : {b[63:32], 32'hFFFF_FFFF};
        end
        2: begin
          a = 64'($signed(12'($urandom)));
          b = 64'($signed(6'($urandom)));
        end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
